compressor_stream_arbiter: RTL
==============================

// Module: compressor_stream_arbiter
// PURPOSE
// - Shares one naiveCompressor input among NUM_SRC byte-stream requesters.
// - Packet-granular round-robin: a source holds the grant from its first beat
//   through the beat with bits_last=1.
// - Exports the current owner id so downstream can tag compressor output; the
//   compressor is combinational, so output beats align with grant_id.
// PARAMETERS
// - NUM_SRC  default 4  number of requesting streams, 2..16
// - ID_W     default 2  width of grant_id, = clog2(NUM_SRC)
// PORTS
// - clock                     in   1          sole clock, rising edge
// - reset                     in   1          asynchronous, active-high
// - src_valid                 in   NUM_SRC    per-source beat valid
// - src_bits_byte             in   8*NUM_SRC  per-source byte, src i at [8i+7:8i]
// - src_bits_last             in   NUM_SRC    per-source end-of-packet flag
// - src_ready                 out  NUM_SRC    per-source ready
// - compressor_in_valid       out  1          to compressor
// - compressor_in_bits_byte   out  8          to compressor
// - compressor_in_bits_last   out  1          to compressor
// - compressor_in_ready       in   1          from compressor
// - grant_valid               out  1          1 while a packet owns the compressor
// - grant_id                  out  ID_W       index of the owning source
// BEHAVIOUR
// - FSM states: IDLE, BUSY (registered). On reset: IDLE, grant_valid=0,
//   grant_id=0, last_grant=NUM_SRC-1 (so src 0 has highest priority first).
// - IDLE
//   - All src_ready=0; compressor_in_valid=0; byte/last driven 0.
//   - If any src_valid: pick the first valid index scanning last_grant+1 upward,
//     wrapping modulo NUM_SRC.
//   - Next edge: grant_id<=pick, grant_valid<=1, state<=BUSY.
//   - Fixed 1-cycle arbitration bubble per packet.
// - BUSY, owner g=grant_id
//   - compressor_in_valid=src_valid[g]; byte/last = source g's.
//   - src_ready[g]=compressor_in_ready; all other src_ready=0.
//   - Combinational pass-through; 0-cycle latency source to compressor.
//   - Beat transfers when src_valid[g] & compressor_in_ready.
//   - Transfer with last=1: next edge -> IDLE, grant_valid<=0, last_grant<=g.
//   - src_valid[g] low mid-packet: stay BUSY and hold the grant indefinitely.
//     Other sources never preempt.
// - Single-beat packet (first beat has last=1): BUSY for exactly 1 cycle if
//   ready is high.
// - Requests arriving in the same cycle are resolved purely by rotating
//   priority. A source that just finished has lowest priority next.
// - Non-owner src_valid/data are ignored.
//   - Sources must hold valid/data stable until ready; the arbiter does not check.
// - Reset asserted mid-packet: immediately IDLE, all outputs to reset values.
//   - Partial packet is abandoned; no recovery beat is emitted.
// - grant_id always < NUM_SRC; ID_W must satisfy 2**ID_W >= NUM_SRC.
// CONFIGURATION
// - Macro COMPARB_PKT_CNT_EN:
//   - Defined: adds output pkt_count [16*NUM_SRC-1:0], one 16-bit counter per
//     source, slice i at [16i+15:16i].
//     - Increments on each accepted last=1 beat from that source.
//     - Wraps 0xFFFF->0; reset to 0.
//   - Undefined: port and counters absent; all other behaviour identical.
// TESTING
// - Reset, then src0 sends 3-beat pkt 'a','B','c', ready=1 -> IDLE 1 cycle;
//   grant_id=0 for 3 cycles; compressor sees 'a','B','c' with last on 'c';
//   then grant_valid=0.
// - src0..src3 all valid with 1-beat pkts -> grants in order 0,1,2,3;
//   each grant lasts 1 cycle followed by 1 IDLE cycle.
// - src1 mid-packet, compressor_in_ready=0 for 5 cycles -> src_ready all 0;
//   grant_id stays 1; byte held; no beat lost or duplicated.
// - src2 finishes, src2 and src3 both request -> src3 granted first.
// - Reset pulse during beat 2 of a 4-beat pkt -> same cycle: grant_valid=0,
//   src_ready=0.
//   - After release, src0 priority is restored.
// - COMPARB_PKT_CNT_EN: 2 pkts from src1, 1 from src3 -> counts [0,2,0,1];
//   preload 0xFFFF via 65535 pkts then +1 -> wraps to 0.

Source files
------------

// File: rtl/compressor_stream_arbiter.sv
// Packet-granular round-robin arbiter sharing one compressor input among NUM_SRC byte streams.
// Optional per-source packet counters are enabled by defining COMPARB_PKT_CNT_EN.
module compressor_stream_arbiter #(
  parameter int NUM_SRC = 4,
  parameter int ID_W    = 2
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [NUM_SRC-1:0]   src_valid,
  input  logic [8*NUM_SRC-1:0] src_bits_byte,
  input  logic [NUM_SRC-1:0]   src_bits_last,
  output logic [NUM_SRC-1:0]   src_ready,
  output logic                 compressor_in_valid,
  output logic [7:0]           compressor_in_bits_byte,
  output logic                 compressor_in_bits_last,
  input  logic                 compressor_in_ready,
  output logic                 grant_valid,
  output logic [ID_W-1:0]      grant_id
`ifdef COMPARB_PKT_CNT_EN
  ,
  output logic [16*NUM_SRC-1:0] pkt_count
`endif
);

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_BUSY = 1'b1} state_e;

  state_e          state_q, state_d;
  logic            grant_valid_q, grant_valid_d;
  logic [ID_W-1:0] grant_id_q, grant_id_d;
  logic [ID_W-1:0] last_grant_q, last_grant_d;
  logic [ID_W-1:0] pick_s;
  logic            any_valid_s;
  logic            owner_valid_s;
  logic            owner_last_s;
  logic [7:0]      owner_byte_s;
  logic            done_s;

  // Owner's beat and end-of-packet detection; grant_id_q is always < NUM_SRC.
  always_comb begin
    owner_valid_s = src_valid[grant_id_q];
    owner_last_s  = src_bits_last[grant_id_q];
    owner_byte_s  = src_bits_byte[{grant_id_q, 3'b000} +: 8];
    done_s        = (state_q == ST_BUSY) & owner_valid_s & compressor_in_ready & owner_last_s;
  end

  // Rotating-priority pick: scanning far-to-near lets the nearest valid source after last_grant win.
  always_comb begin
    int idx;
    pick_s      = '0;
    any_valid_s = |src_valid;
    for (int k = NUM_SRC; k >= 1; k--) begin
      idx    = (int'(last_grant_q) + k) % NUM_SRC;
      pick_s = src_valid[idx] ? ID_W'(idx) : pick_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d       = state_q;
    grant_valid_d = grant_valid_q;
    grant_id_d    = grant_id_q;
    last_grant_d  = last_grant_q;
    case (state_q)
      ST_IDLE: begin
        if (any_valid_s) begin
          state_d       = ST_BUSY;
          grant_valid_d = 1'b1;
          grant_id_d    = pick_s;
        end else begin
          state_d       = ST_IDLE;
          grant_valid_d = 1'b0;
        end
      end
      ST_BUSY: begin
        if (done_s) begin
          state_d       = ST_IDLE;
          grant_valid_d = 1'b0;
          last_grant_d  = grant_id_q;
        end else begin
          state_d       = ST_BUSY;
          grant_valid_d = 1'b1;
        end
      end
      default: begin
        state_d       = ST_IDLE;
        grant_valid_d = 1'b0;
      end
    endcase
  end

  // Output logic: zero-latency pass-through of the owning source while BUSY.
  always_comb begin
    src_ready               = '0;
    compressor_in_valid     = 1'b0;
    compressor_in_bits_byte = 8'h00;
    compressor_in_bits_last = 1'b0;
    case (state_q)
      ST_IDLE: begin
        src_ready               = '0;
        compressor_in_valid     = 1'b0;
      end
      ST_BUSY: begin
        src_ready[grant_id_q]   = compressor_in_ready;
        compressor_in_valid     = owner_valid_s;
        compressor_in_bits_byte = owner_byte_s;
        compressor_in_bits_last = owner_last_s;
      end
      default: begin
        src_ready               = '0;
        compressor_in_valid     = 1'b0;
      end
    endcase
  end

  // State register; last_grant resets to NUM_SRC-1 so source 0 wins first.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      grant_valid_q <= 1'b0;
      grant_id_q    <= '0;
      last_grant_q  <= ID_W'(NUM_SRC - 1);
    end else begin
      state_q       <= state_d;
      grant_valid_q <= grant_valid_d;
      grant_id_q    <= grant_id_d;
      last_grant_q  <= last_grant_d;
    end
  end

  assign grant_valid = grant_valid_q;
  assign grant_id    = grant_id_q;

`ifdef COMPARB_PKT_CNT_EN
  logic [16*NUM_SRC-1:0] pkt_count_q, pkt_count_d;

  // Per-source completed-packet counters, wrapping at 16 bits.
  always_comb begin
    pkt_count_d = pkt_count_q;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (done_s && (grant_id_q == ID_W'(i))) begin
        pkt_count_d[16*i +: 16] = pkt_count_q[16*i +: 16] + 16'd1;
      end else begin
        pkt_count_d[16*i +: 16] = pkt_count_q[16*i +: 16];
      end
    end
  end

  // Counter register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pkt_count_q <= '0;
    end else begin
      pkt_count_q <= pkt_count_d;
    end
  end

  assign pkt_count = pkt_count_q;
`endif

endmodule
